// File: rtl/mod_instruction_fetch.sv
// Instruction-fetch sequencer: drives the instruction ROM from the PC and registers
// fetched words into the IF/ID boundary, with stall, redirect and end-of-memory halt.
module mod_instruction_fetch #(
  parameter logic [29:0] RESET_PC = 30'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [29:0] rom_address,
  input  logic [31:0] rom_instruction,
  input  logic        rom_mem_end,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [29:0] redirect_address,
  output logic [31:0] instr,
  output logic [29:0] instr_pc,
  output logic        instr_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam int unsigned PC_W    = 30;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 32;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [PC_W-1:0]    pc, pc_nxt;
  logic [INSTR_W-1:0] instr_nxt;
  logic [PC_W-1:0]    instr_pc_nxt;
  logic               instr_valid_nxt;
  logic [CNT_W-1:0]   fetch_count_nxt;

  // State and IF/ID registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr       <= instr_nxt;
      instr_pc    <= instr_pc_nxt;
      instr_valid <= instr_valid_nxt;
      fetch_count <= fetch_count_nxt;
    end
  end

  // Next-state logic, priority: redirect, stall, end-of-memory, fetch.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    instr_nxt       = instr;
    instr_pc_nxt    = instr_pc;
    instr_valid_nxt = instr_valid;
    fetch_count_nxt = fetch_count;

    if (redirect_valid) begin
      state_nxt       = ST_RUN;
      pc_nxt          = redirect_address;
      instr_valid_nxt = 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (!stall) begin
            if (rom_mem_end) begin
              state_nxt       = ST_HALT;
              instr_valid_nxt = 1'b0;
            end else begin
              instr_nxt       = rom_instruction;
              instr_pc_nxt    = pc;
              instr_valid_nxt = 1'b1;
              pc_nxt          = pc + PC_W'(1);
              fetch_count_nxt = fetch_count + CNT_W'(1);
            end
          end
        end
        ST_HALT: begin
          instr_valid_nxt = 1'b0;
        end
        default: begin
          state_nxt = ST_RUN;
        end
      endcase
    end
  end

  assign rom_address = pc;
  assign halted      = (state == ST_HALT);

endmodule

// File: tb/tb_mod_instruction_fetch.sv
// Directed bench for mod_instruction_fetch: two instances, one from address 0 against
// a small ROM model, one from near the top of the address space to cover PC wrap.
module tb_mod_instruction_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: RESET_PC = 0
  logic        reset_n0, stall0, redirect_valid0;
  logic [29:0] redirect_address0, rom_address0, instr_pc0;
  logic [31:0] rom_instruction0, instr0, fetch_count0;
  logic        rom_mem_end0, instr_valid0, halted0;

  // Instance 1: RESET_PC near the wrap point, every address valid
  logic        reset_n1, stall1, redirect_valid1;
  logic [29:0] redirect_address1, rom_address1, instr_pc1;
  logic [31:0] rom_instruction1, instr1, fetch_count1;
  logic        rom_mem_end1, instr_valid1, halted1;

  logic        first_mode;
  logic [29:0] rom_last;

  int checks = 0;
  int errors = 0;

  // ROM model for instance 0
  always_comb begin
    if (first_mode && rom_address0 == 30'd0) rom_instruction0 = 32'h2001000D;
    else                                     rom_instruction0 = 32'd100 + {2'b00, rom_address0};
    rom_mem_end0 = (rom_address0 > rom_last);
  end

  assign rom_instruction1 = 32'hC0DE0000 ^ {2'b00, rom_address1};
  assign rom_mem_end1     = 1'b0;

  mod_instruction_fetch #(.RESET_PC(30'd0)) dut0 (
    .clk(clk), .reset_n(reset_n0), .rom_address(rom_address0),
    .rom_instruction(rom_instruction0), .rom_mem_end(rom_mem_end0),
    .stall(stall0), .redirect_valid(redirect_valid0), .redirect_address(redirect_address0),
    .instr(instr0), .instr_pc(instr_pc0), .instr_valid(instr_valid0),
    .halted(halted0), .fetch_count(fetch_count0)
  );

  mod_instruction_fetch #(.RESET_PC(30'h3FFFFFFE)) dut1 (
    .clk(clk), .reset_n(reset_n1), .rom_address(rom_address1),
    .rom_instruction(rom_instruction1), .rom_mem_end(rom_mem_end1),
    .stall(stall1), .redirect_valid(redirect_valid1), .redirect_address(redirect_address1),
    .instr(instr1), .instr_pc(instr_pc1), .instr_valid(instr_valid1),
    .halted(halted1), .fetch_count(fetch_count1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed %h expected %h", tag, observed, expected);
      end
  endtask

  task automatic chk0(input string tag, input logic [31:0] e_instr, input logic [29:0] e_pc,
                      input logic e_valid, input logic e_halt, input logic [31:0] e_cnt,
                      input logic [29:0] e_addr);
    chk({tag, ".instr"},       instr0,               e_instr);
    chk({tag, ".instr_pc"},    {2'b00, instr_pc0},   {2'b00, e_pc});
    chk({tag, ".instr_valid"}, {31'd0, instr_valid0}, {31'd0, e_valid});
    chk({tag, ".halted"},      {31'd0, halted0},     {31'd0, e_halt});
    chk({tag, ".fetch_count"}, fetch_count0,         e_cnt);
    chk({tag, ".rom_address"}, {2'b00, rom_address0}, {2'b00, e_addr});
  endtask

  task automatic chk1(input string tag, input logic [31:0] e_instr, input logic [29:0] e_pc,
                      input logic e_valid, input logic [31:0] e_cnt, input logic [29:0] e_addr);
    chk({tag, ".instr"},       instr1,               e_instr);
    chk({tag, ".instr_pc"},    {2'b00, instr_pc1},   {2'b00, e_pc});
    chk({tag, ".instr_valid"}, {31'd0, instr_valid1}, {31'd0, e_valid});
    chk({tag, ".halted"},      {31'd0, halted1},     32'd0);
    chk({tag, ".fetch_count"}, fetch_count1,         e_cnt);
    chk({tag, ".rom_address"}, {2'b00, rom_address1}, {2'b00, e_addr});
  endtask

  initial begin
    reset_n0 = 1'b0; stall0 = 1'b0; redirect_valid0 = 1'b0; redirect_address0 = '0;
    reset_n1 = 1'b0; stall1 = 1'b0; redirect_valid1 = 1'b0; redirect_address1 = '0;
    first_mode = 1'b1; rom_last = 30'd0;

    // Reset and first fetch
    step(); step();
    chk0("rst", 32'd0, 30'd0, 1'b0, 1'b0, 32'd0, 30'd0);
    reset_n0 = 1'b1;
    step();
    chk0("first", 32'h2001000D, 30'd0, 1'b1, 1'b0, 32'd1, 30'd1);
    step();
    chk0("first_halt", 32'h2001000D, 30'd0, 1'b0, 1'b1, 32'd1, 30'd1);

    // Sequential fetch with a 3-cycle stall
    reset_n0 = 1'b0;
    step();
    first_mode = 1'b0; rom_last = 30'd7; reset_n0 = 1'b1;
    step(); chk0("seq0", 32'd100, 30'd0, 1'b1, 1'b0, 32'd1, 30'd1);
    step(); chk0("seq1", 32'd101, 30'd1, 1'b1, 1'b0, 32'd2, 30'd2);
    step(); chk0("seq2", 32'd102, 30'd2, 1'b1, 1'b0, 32'd3, 30'd3);
    stall0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk0("stall", 32'd102, 30'd2, 1'b1, 1'b0, 32'd3, 30'd3);
    end
    stall0 = 1'b0;
    step(); chk0("seq3", 32'd103, 30'd3, 1'b1, 1'b0, 32'd4, 30'd4);
    step(); chk0("seq4", 32'd104, 30'd4, 1'b1, 1'b0, 32'd5, 30'd5);
    step(); chk0("seq5", 32'd105, 30'd5, 1'b1, 1'b0, 32'd6, 30'd6);
    step(); chk0("seq6", 32'd106, 30'd6, 1'b1, 1'b0, 32'd7, 30'd7);
    step(); chk0("seq7", 32'd107, 30'd7, 1'b1, 1'b0, 32'd8, 30'd8);
    step(); chk0("halt8", 32'd107, 30'd7, 1'b0, 1'b1, 32'd8, 30'd8);
    stall0 = 1'b1;
    step(); chk0("halt_stall", 32'd107, 30'd7, 1'b0, 1'b1, 32'd8, 30'd8);
    stall0 = 1'b0;

    // Redirect out of HALT
    redirect_valid0 = 1'b1; redirect_address0 = 30'd2;
    step(); chk0("unhalt", 32'd107, 30'd7, 1'b0, 1'b0, 32'd8, 30'd2);
    redirect_valid0 = 1'b0;
    step(); chk0("resume2", 32'd102, 30'd2, 1'b1, 1'b0, 32'd9, 30'd3);
    step(); chk0("resume3", 32'd103, 30'd3, 1'b1, 1'b0, 32'd10, 30'd4);

    // Redirect wins over a simultaneous stall
    redirect_valid0 = 1'b1; redirect_address0 = 30'd5; stall0 = 1'b1;
    step(); chk0("redir_bubble", 32'd103, 30'd3, 1'b0, 1'b0, 32'd10, 30'd5);
    redirect_valid0 = 1'b0; stall0 = 1'b0;
    step(); chk0("redir_tgt", 32'd105, 30'd5, 1'b1, 1'b0, 32'd11, 30'd6);

    // Reset together with redirect: reset values win
    reset_n0 = 1'b0; redirect_valid0 = 1'b1; redirect_address0 = 30'd6; stall0 = 1'b1;
    step(); chk0("rst_redir", 32'd0, 30'd0, 1'b0, 1'b0, 32'd0, 30'd0);
    reset_n0 = 1'b1; redirect_valid0 = 1'b0; stall0 = 1'b0;

    // PC wrap-around on the second instance
    reset_n1 = 1'b0;
    step();
    reset_n1 = 1'b1;
    step(); chk1("wrap0", 32'hFF21FFFE, 30'h3FFFFFFE, 1'b1, 32'd1, 30'h3FFFFFFF);
    step(); chk1("wrap1", 32'hFF21FFFF, 30'h3FFFFFFF, 1'b1, 32'd2, 30'h00000000);
    step(); chk1("wrap2", 32'hC0DE0000, 30'h00000000, 1'b1, 32'd3, 30'h00000001);
    reset_n1 = 1'b0; redirect_valid1 = 1'b1; redirect_address1 = 30'd7; stall1 = 1'b1;
    step(); chk1("wrap_rst", 32'd0, 30'd0, 1'b0, 32'd0, 30'h3FFFFFFE);
    reset_n1 = 1'b1; redirect_valid1 = 1'b0; stall1 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_instruction_fetch.md
# mod_instruction_fetch

Instruction-fetch sequencer that drives the instruction ROM and delivers fetched words to the decode stage. It holds the program counter (PC), presents the PC as a word address to the ROM, and registers the returned instruction into the IF/ID boundary. It stops fetching when the ROM reports end-of-memory. It also accepts stalls from decode and PC redirects from branch/jump resolution.

## Interface
- RESET_PC, 0, word address loaded into PC on reset (30-bit).
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- rom_address  output  30  word address to ROM; equals PC register.
- rom_instruction  input  32  combinational ROM data for rom_address.
- rom_mem_end  input  1  ROM flag: rom_address is past the last valid word.
- stall  input  1  decode cannot accept; hold IF/ID and PC.
- redirect_valid  input  1  branch/jump taken; load new PC, flush IF/ID.
- redirect_address  input  30  target word address for redirect.
- instr  output  32  registered instruction to decode.
- instr_pc  output  30  word address instr was fetched from.
- instr_valid  output  1  instr/instr_pc hold a live instruction.
- halted  output  1  fetch stopped at end-of-memory.
- fetch_count  output  32  number of instructions delivered (instr_valid set by a fetch), wraps at 2^32.

## Operation
- States: RUN, HALT. halted = (state == HALT).
- Reset (reset_n low at edge): state=RUN, PC=RESET_PC, instr=0, instr_pc=0, instr_valid=0, fetch_count=0. This overrides all other inputs, including mid-stall and mid-redirect.
- Priority per cycle, highest first: reset, redirect, stall, end-of-memory, normal fetch.
- Redirect (any state): PC<=redirect_address, instr_valid<=0, state<=RUN. instr and instr_pc hold their values, and fetch_count is unchanged. The word at the old PC is discarded. This applies even when stall is high.
- Stall (RUN, no redirect): PC, instr, instr_pc, instr_valid and fetch_count all hold.
- End-of-memory (RUN, no redirect, no stall, rom_mem_end=1): state<=HALT, instr_valid<=0, and PC holds. The word is not latched.
- Normal fetch (RUN, no redirect, no stall, rom_mem_end=0):
  - instr<=rom_instruction, instr_pc<=PC, instr_valid<=1.
  - PC<=PC+1, modulo 2^30, so 30'h3FFFFFFF wraps to 0.
  - fetch_count<=fetch_count+1.
- HALT: all registers hold and instr_valid stays 0. Stall has no effect. Only a redirect or reset leaves HALT.

## Timing
- rom_address comes directly from the PC register and is valid the whole cycle. The ROM is combinational, so rom_instruction is sampled at the next edge.
- Fetch latency: the word at address A appears on instr, with instr_valid=1, one cycle after the PC equals A.
- Throughput: one instruction per cycle while unstalled.
- Redirect to T in cycle n:
  - The PC equals T in cycle n+1.
  - The instruction at T is valid in cycle n+2.
  - instr_valid is 0 in cycle n+1 (one bubble).
- End-of-memory at PC=E in cycle n: halted=1 and instr_valid=0 from cycle n+1. rom_address stays E.
- Stall asserted in cycle n: outputs in cycle n+1 equal those in cycle n. Release resumes with no lost or duplicated instruction.
- Outputs change only on the clock edge. There is no combinational path from the inputs to any output.

## Test plan
- Reset/first fetch: ROM word 0 = 32'h2001000D, mem_end for address>0, RESET_PC=0. Hold reset_n low 2 cycles, then release.
  - During reset: all outputs 0 and rom_address=0.
  - First edge after release: instr=32'h2001000D, instr_pc=0, instr_valid=1, fetch_count=1.
  - Next edge: halted=1, instr_valid=0, rom_address=1, fetch_count stays 1.
- Sequential + stall: ROM words 0..7 = 100+i, mem_end above 7. Assert stall for 3 cycles while instr=102.
  - instr, instr_pc and fetch_count hold for those 3 cycles.
  - After release the sequence continues 103, 104, with no gaps or repeats.
  - Halt occurs after 107 with fetch_count=8.
- Redirect: during sequential fetch, pulse redirect_valid with redirect_address=5 and stall=1 simultaneously.
  - Next cycle: instr_valid=0, rom_address=5.
  - Following cycle: instr=105, instr_pc=5.
- Redirect out of HALT: after halting at address 8, pulse redirect_valid with target 2.
  - halted drops the next cycle.
  - Fetch resumes: instr=102, then 103.
- Wrap-around and reset mid-operation:
  - With RESET_PC=30'h3FFFFFFE and all addresses valid: instr_pc runs 3FFFFFFE, 3FFFFFFF, 0, and fetch_count increments each cycle.
  - Assert reset_n=0 together with redirect_valid=1: the reset values win (PC=RESET_PC, instr_valid=0).
